serial_addsub4: RTL and testbench
=================================

# serial_addsub4

Bit-serial adder/subtractor built around a single full-adder slice and a registered carry. It processes one operand bit per clock, LSB first, and reports sum or difference, carry/no-borrow and signed overflow. It is the sequential, area-reduced counterpart of the team's parallel 4-bit ripple-carry adder, and adds a subtract direction. It sits behind a start/done handshake so a controller can time-share one slice across wider words.

## Interface
- WIDTH, 4, operand and result width in bits; must be ≥2.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- SUB  in  1  0 = A+B, 1 = A−B; sampled with start.
- A  in  WIDTH  operand A; sampled with start.
- B  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; S/Co/V are valid from this cycle on.
- S  out  WIDTH  result register.
- Co  out  1  final carry. For add, 1 = unsigned overflow. For sub, 1 = no borrow (A ≥ B unsigned).
- V  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
  - IDLE: when start=1, latch A into opA and B XOR {WIDTH{SUB}} into opB. Set carry = SUB and count = 0, then go to RUN. When start=0, stay in IDLE.
  - RUN: each edge performs one step.
    - s = opA[0] ^ opB[0] ^ carry.
    - carry ← majority(opA[0], opB[0], carry).
    - Shift opA and opB right by one.
    - Shift s into the MSB of the internal shift register acc.
    - count ← count+1.
    - On the step where count = WIDTH−1, record the incoming carry as cmsb. Load S ← final acc, Co ← new carry, V ← cmsb ^ new carry. Go to DONE.
  - DONE: done=1 for one cycle, then unconditionally return to IDLE.
- start is ignored in RUN and DONE. It is not queued.
- SUB, A and B are don't-care except in the IDLE cycle where start is accepted.
- S, Co and V change only on entry to DONE. They hold the previous result through IDLE and RUN of the next operation.
- Arithmetic is modulo 2^WIDTH. No saturation.
- count is ceil(log2(WIDTH+1)) bits wide. It is never compared beyond WIDTH−1.

## Timing
- Reset: on any edge with rst=1, the block goes to IDLE with busy=0, done=0, S=0, Co=0, V=0. opA, opB, acc, carry and count are all cleared.
- rst has priority over start and over every state transition.
- Reset during RUN or DONE aborts the operation: no done pulse, outputs cleared.
- Acceptance edge E (IDLE, start=1): busy=1 from E.
- Edges E+1 … E+WIDTH process bits 0 … WIDTH−1.
- After edge E+WIDTH: state is DONE, busy=0, done=1, and S/Co/V hold the new result.
- After edge E+WIDTH+1: state is IDLE. The earliest next acceptance is edge E+WIDTH+2.
- Latency from acceptance to done is WIDTH cycles. Issue interval is WIDTH+2 cycles.
- start held high continuously yields back-to-back operations every WIDTH+2 cycles. The operands are re-sampled at each acceptance.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
All cases use WIDTH=4.
- **Add with signed overflow:** reset, then start with SUB=0, A=0011, B=0101. Required: done exactly 4 cycles after acceptance, S=1000, Co=0, V=1, busy high for exactly 4 cycles.
- **Add with wrap-around:** SUB=0, A=1111, B=0001. Required: S=0000, Co=1, V=0.
- **Subtract without borrow:**
  - SUB=1, A=0101, B=0011. Required: S=0010, Co=1, V=0.
  - SUB=1, A=0011, B=0101. Required: S=1110, Co=0, V=0.
- **Subtract with signed overflow:** SUB=1, A=1000, B=0001. Required: S=0111, Co=1, V=1.
  - Then SUB=1, A=0000, B=0000. Required: S=0000, Co=1, V=0.
- **start during RUN/DONE:** pulse start with different operands in RUN and again in DONE. Required: both are ignored; the result matches the first operation; the next acceptance is no earlier than edge E+6.
  - Hold start high continuously. Required: done pulses every 6 cycles.
- **Reset mid-operation:** assert rst on the edge after bit 1 is processed. Required: the next cycle shows IDLE with busy=0, done=0, S=0, Co=0, V=0, and no later done pulse.
  - A following start with A=0111, B=0001, SUB=0. Required: S=1000, V=1, unaffected by the aborted operation.

Source files
------------

// File: rtl/serial_addsub4.sv
// Bit-serial adder/subtractor: one full-adder slice and a registered carry,
// LSB first, with a start/done handshake and registered S/Co/V results.
module serial_addsub4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             V
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] op_a_r;
    logic [WIDTH-1:0] op_b_r;
    logic [WIDTH-1:0] acc_r;
    logic             carry_r;
    logic [CW-1:0]    count_r;

    logic             sum_s;
    logic             carry_next_s;
    logic [WIDTH-1:0] acc_next_s;

    // Returns {carry_out, sum} of a single full-adder slice.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
        return {(x & y) | (x & cin) | (y & cin), x ^ y ^ cin};
    endfunction

    // The single adder slice and the shift-in of its sum bit.
    always_comb begin
        {carry_next_s, sum_s} = full_add(op_a_r[0], op_b_r[0], carry_r);
        acc_next_s            = {sum_s, acc_r[WIDTH-1:1]};
    end

    // Control FSM, operand shifters, carry chain and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            op_a_r  <= '0;
            op_b_r  <= '0;
            acc_r   <= '0;
            carry_r <= 1'b0;
            count_r <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            S       <= '0;
            Co      <= 1'b0;
            V       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B and seed the carry.
                        op_a_r  <= A;
                        op_b_r  <= B ^ {WIDTH{SUB}};
                        carry_r <= SUB;
                        count_r <= '0;
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    op_a_r  <= op_a_r >> 1;
                    op_b_r  <= op_b_r >> 1;
                    acc_r   <= acc_next_s;
                    carry_r <= carry_next_s;
                    count_r <= count_r + CW'(1);
                    if (count_r == LAST) begin
                        // carry_r here is the carry into the MSB.
                        S       <= acc_next_s;
                        Co      <= carry_next_s;
                        V       <= carry_r ^ carry_next_s;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub4.sv
// Scoreboard bench for serial_addsub4: a stimulus process queues expected
// results from an arithmetic model; a negedge monitor checks every done pulse.
module tb_serial_addsub4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;
    logic         v;

    always #5 clk = ~clk;

    serial_addsub4 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .SUB(sub), .A(a), .B(b),
        .busy(busy), .done(done), .S(s), .Co(co), .V(v)
    );

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    logic [W+1:0] exp_q[$];
    int           acc_q[$];
    logic [W+1:0] last_res = '0;
    logic [W+1:0] mon_e;
    int           mon_t;
    int           busy_cnt = 0;
    logic         busy_prev = 1'b0;
    bit           cont_mode = 1'b0;
    int           prev_acc = -1;
    int           n_cont = 0;
    bit           accepted = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // Expected {S, Co, V} from plain unsigned and signed integer arithmetic.
    function automatic logic [W+1:0] model(input logic op_sub, input logic [W-1:0] xa, input logic [W-1:0] xb);
        int ua = int'(xa);
        int ub = int'(xb);
        int sa = xa[W-1] ? ua - (1 << W) : ua;
        int sbv = xb[W-1] ? ub - (1 << W) : ub;
        int ur;
        int sr;
        logic c;
        logic ov;
        if (op_sub) begin
            ur = ua - ub;
            sr = sa - sbv;
            c  = (ua >= ub);
        end else begin
            ur = ua + ub;
            sr = sa + sbv;
            c  = (ur >= (1 << W));
        end
        ov = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        return {W'(ur), c, ov};
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_t = acc_q.pop_front();
                chk("result", 32'({s, co, v}), 32'(mon_e));
                chk("latency", 32'(cyc - mon_t), 32'(W));
                chk("busy_cycles", 32'(busy_cnt), 32'(W));
                last_res = mon_e;
            end
            busy_cnt = 0;
        end else begin
            chk("hold", 32'({s, co, v}), 32'(last_res));
            if (busy === 1'b1) busy_cnt++;
        end
        if (rst === 1'b1) begin
            exp_q.delete();
            acc_q.delete();
            last_res = '0;
            busy_cnt = 0;
        end
    end

    task automatic step(input logic r, input logic st, input logic sb,
                        input logic [W-1:0] aa, input logic [W-1:0] bb);
        @(posedge clk);
        #2;
        if (busy === 1'b1 && busy_prev === 1'b0) begin
            exp_q.push_back(model(sub, a, b));
            acc_q.push_back(cyc);
            accepted = 1'b1;
            if (cont_mode) begin
                if (prev_acc >= 0) chk("issue_interval", 32'(cyc - prev_acc), 32'(W + 2));
                prev_acc = cyc;
                n_cont++;
            end
        end
        busy_prev = busy;
        rst   = r;
        start = st;
        sub   = sb;
        a     = aa;
        b     = bb;
    endtask

    task automatic run_op(input logic sb, input logic [W-1:0] aa, input logic [W-1:0] bb);
        accepted = 1'b0;
        step(1'b0, 1'b1, sb, aa, bb);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        chk("accepted", 32'(accepted), 32'd1);
        repeat (5) step(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, '0, '0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_outs", 32'({s, co, v}), 32'd0);
        step(1'b0, 1'b0, 1'b0, '0, '0);

        run_op(1'b0, 4'b0011, 4'b0101);
        run_op(1'b0, 4'b1111, 4'b0001);
        run_op(1'b1, 4'b0101, 4'b0011);
        run_op(1'b1, 4'b0011, 4'b0101);
        run_op(1'b1, 4'b1000, 4'b0001);
        run_op(1'b1, 4'b0000, 4'b0000);

        // start pulses during RUN and during DONE must be ignored
        accepted = 1'b0;
        step(1'b0, 1'b1, 1'b0, 4'b0011, 4'b0101);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        chk("accepted", 32'(accepted), 32'd1);
        step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b1, 4'b1001, 4'b1001);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        chk("no_accept_in_done", 32'(busy), 32'd0);
        repeat (4) step(1'b0, 1'b0, 1'b0, '0, '0);

        for (int i = 0; i < 20; i++) run_op(1'($urandom), W'($urandom), W'($urandom));

        cont_mode = 1'b1;
        prev_acc  = -1;
        repeat (20) step(1'b0, 1'b1, 1'($urandom), W'($urandom), W'($urandom));
        cont_mode = 1'b0;
        repeat (8) step(1'b0, 1'b0, 1'b0, '0, '0);
        chk("cont_accepts", 32'(n_cont >= 3), 32'd1);

        // reset on the edge after bit 1 has been processed
        run_op(1'b0, 4'b1001, 4'b0110);
        accepted = 1'b0;
        step(1'b0, 1'b1, 1'b0, 4'b0101, 4'b0110);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        chk("accepted", 32'(accepted), 32'd1);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_outs", 32'({s, co, v}), 32'd0);
        repeat (8) step(1'b0, 1'b0, 1'b0, '0, '0);
        run_op(1'b0, 4'b0111, 4'b0001);

        repeat (3) step(1'b0, 1'b0, 1'b0, '0, '0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
